// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op encodings and FSM state type for the iterative divide/sqrt unit
package fpu_pkg;
    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_SQRT = 1'b1;
    typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/fpu_divsqrt_iter_if.sv
// fpu_divsqrt_iter_if: request/result bundle between execute stage (master) and divide/sqrt unit (slave)
//   start/op/a/b/cancel : request side, driven by the master
//   busy/count          : stall window and iterations remaining
//   done/q/r/dz/inv     : one-cycle completion pulse with held results and flags
interface fpu_divsqrt_iter_if #(parameter int WIDTH = 32);
    localparam int COUNT_W = $clog2(WIDTH) + 1;
    logic               start;
    logic               op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               cancel;
    logic               busy;
    logic [COUNT_W-1:0] count;
    logic               done;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    logic               dz;
    logic               inv;
    modport master (output start, op, a, b, cancel, input busy, count, done, q, r, dz, inv);
    modport slave  (input start, op, a, b, cancel, output busy, count, done, q, r, dz, inv);
endinterface

// File: rtl/divsqrt_step.sv
// divsqrt_step: one restoring iteration shared by divide and square root
//   i_rem   : current partial remainder
//   i_in    : next operand bits (divide uses i_in[1] only, sqrt uses both)
//   i_trial : value to subtract (divisor, or {root, 2'b01} for sqrt)
//   i_sqrt  : select the 2-bit sqrt shift instead of the 1-bit divide shift
//   o_rem   : next partial remainder
//   o_bit   : next quotient/root bit
module divsqrt_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [1:0]       i_in,
    input  logic [WIDTH-1:0] i_trial,
    input  logic             i_sqrt,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_bit
);
    logic [WIDTH:0] w_shift;
    assign w_shift = i_sqrt ? {i_rem[WIDTH-2:0], i_in} : {i_rem, i_in[1]};
    assign o_bit   = w_shift >= {1'b0, i_trial};
    // a successful subtract always leaves a result that fits WIDTH bits
    assign o_rem   = o_bit ? w_shift[WIDTH-1:0] - i_trial : w_shift[WIDTH-1:0];
endmodule

// File: rtl/fpu_divsqrt_iter.sv
// fpu_divsqrt_iter: iterative radix-2 unsigned divide / square root, one bit per cycle
//   i_clk : clock
//   i_clr : asynchronous active-high clear
//   s_bus : slave side of fpu_divsqrt_iter_if (start/op/a/b/cancel in; busy/count/done/q/r/dz/inv out)
// FPU_DIVSQRT_SQRT_EN: when defined the sqrt datapath is enabled; otherwise op=1 completes
// on the next edge with inv=1 and zero results.
module fpu_divsqrt_iter #(parameter int WIDTH = 32) (
    input logic i_clk,
    input logic i_clr,
    fpu_divsqrt_iter_if.slave s_bus
);
    import fpu_pkg::*;
    localparam int COUNT_W = $clog2(WIDTH) + 1;
    localparam logic [COUNT_W-1:0] N_DIV  = COUNT_W'(WIDTH);
    localparam logic [COUNT_W-1:0] N_SQRT = COUNT_W'(WIDTH / 2);
    state_t             r_state, w_state;
    logic [COUNT_W-1:0] r_count, w_count;
    logic               r_op, w_op;
    logic [WIDTH-1:0]   r_num, w_num;
    logic [WIDTH-1:0]   r_den, w_den;
    logic [WIDTH-1:0]   r_quo, w_quo;
    logic [WIDTH-1:0]   r_rem, w_rem;
    logic [WIDTH-1:0]   r_q, w_q;
    logic [WIDTH-1:0]   r_r, w_r;
    logic               r_done, w_done;
    logic               r_dz, w_dz;
    logic               r_inv, w_inv;
    logic [WIDTH-1:0]   w_trial;
    logic [WIDTH-1:0]   w_rem_step;
    logic               w_bit;
    assign w_trial = (r_op == OP_SQRT) ? {r_quo[WIDTH-3:0], 2'b01} : r_den;
    divsqrt_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_in   (r_num[WIDTH-1:WIDTH-2]),
        .i_trial(w_trial),
        .i_sqrt (r_op == OP_SQRT),
        .o_rem  (w_rem_step),
        .o_bit  (w_bit)
    );
    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_op    = r_op;
        w_num   = r_num;
        w_den   = r_den;
        w_quo   = r_quo;
        w_rem   = r_rem;
        w_q     = r_q;
        w_r     = r_r;
        w_dz    = r_dz;
        w_inv   = r_inv;
        w_done  = 1'b0;
        if (s_bus.cancel) begin
            w_state = S_IDLE;
            w_count = '0;
        end else if (r_state == S_RUN) begin
            w_count = r_count - COUNT_W'(1);
            w_num   = (r_op == OP_SQRT) ? {r_num[WIDTH-3:0], 2'b00} : {r_num[WIDTH-2:0], 1'b0};
            w_quo   = {r_quo[WIDTH-2:0], w_bit};
            w_rem   = w_rem_step;
            if (r_count == COUNT_W'(1)) begin
                w_state = S_IDLE;
                w_done  = 1'b1;
                w_q     = {r_quo[WIDTH-2:0], w_bit};
                w_r     = w_rem_step;
                // all-ones quotient and r=a fall out of the iteration itself when b=0
                w_dz    = (r_op == OP_DIV) && (r_den == '0);
                w_inv   = 1'b0;
            end
        end else if (s_bus.start) begin
`ifdef FPU_DIVSQRT_SQRT_EN
            w_state = S_RUN;
            w_op    = s_bus.op;
            w_num   = s_bus.a;
            w_den   = s_bus.b;
            w_quo   = '0;
            w_rem   = '0;
            w_count = (s_bus.op == OP_SQRT) ? N_SQRT : N_DIV;
`else
            if (s_bus.op == OP_SQRT) begin
                w_done = 1'b1;
                w_inv  = 1'b1;
                w_dz   = 1'b0;
                w_q    = '0;
                w_r    = '0;
            end else begin
                w_state = S_RUN;
                w_op    = OP_DIV;
                w_num   = s_bus.a;
                w_den   = s_bus.b;
                w_quo   = '0;
                w_rem   = '0;
                w_count = N_DIV;
            end
`endif
        end
    end
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_op    <= OP_DIV;
            r_num   <= '0;
            r_den   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_count <= w_count;
            r_op    <= w_op;
            r_num   <= w_num;
            r_den   <= w_den;
            r_quo   <= w_quo;
            r_rem   <= w_rem;
            r_q     <= w_q;
            r_r     <= w_r;
            r_done  <= w_done;
            r_dz    <= w_dz;
            r_inv   <= w_inv;
        end
    end
    assign s_bus.busy  = (r_state == S_RUN);
    assign s_bus.count = r_count;
    assign s_bus.done  = r_done;
    assign s_bus.q     = r_q;
    assign s_bus.r     = r_r;
    assign s_bus.dz    = r_dz;
    assign s_bus.inv   = r_inv;
endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// tb_fpu_divsqrt_iter: directed vector table plus hand sequences for busy/cancel/clr corners
module tb_fpu_divsqrt_iter;
    localparam int W  = 32;
    localparam int CW = 6;
    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        inv;
        int          lat;
    } vec_t;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int checks = 0;
    int failures = 0;
    fpu_divsqrt_iter_if #(.WIDTH(W)) bus ();
    fpu_divsqrt_iter #(.WIDTH(W)) dut (.i_clk(clk), .i_clr(clr), .s_bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input int n, output int busy_cyc, output bit seq_ok, output bit seen);
        busy_cyc = 0;
        seq_ok   = 1'b1;
        seen     = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_cyc++;
                if (!bus.busy || bus.count != CW'(n - k)) seq_ok = 1'b0;
                @(negedge clk);
            end
        end
    endtask
    task automatic chk_zero(input string name);
        chk({name, "_q"}, 64'(bus.q), 64'd0);
        chk({name, "_r"}, 64'(bus.r), 64'd0);
        chk({name, "_ctl"}, 64'({bus.busy, bus.count, bus.done, bus.dz, bus.inv}), 64'd0);
    endtask
    task automatic chk_no_done(input string name, input int cycles);
        bit bad = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            if (bus.done || bus.busy) bad = 1'b1;
            @(negedge clk);
        end
        chk(name, 64'(bad), 64'd0);
    endtask
    initial begin
        vec_t tv[$];
        int bc;
        bit ok;
        bit seen;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        tv.push_back('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32});
        tv.push_back('{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 32});
        tv.push_back('{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 32});
        tv.push_back('{1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0, 32});
        tv.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32});
        tv.push_back('{1'b0, 32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'hF, 1'b0, 1'b0, 32});
`ifdef FPU_DIVSQRT_SQRT_EN
        tv.push_back('{1'b1, 32'd1000000, 32'd0, 32'd1000, 32'd0, 1'b0, 1'b0, 16});
        tv.push_back('{1'b1, 32'd10, 32'd0, 32'd3, 32'd1, 1'b0, 1'b0, 16});
        tv.push_back('{1'b1, 32'hFFFFFFFF, 32'd0, 32'd65535, 32'd131070, 1'b0, 1'b0, 16});
        tv.push_back('{1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16});
        tv.push_back('{1'b1, 32'd1, 32'd3, 32'd1, 32'd0, 1'b0, 1'b0, 16});
`else
        tv.push_back('{1'b1, 32'd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0});
`endif
        tv.push_back('{1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b0, 32});
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            launch(tv[i].op, tv[i].a, tv[i].b);
            wait_done(tv[i].lat, bc, ok, seen);
            chk($sformatf("v%0d_done", i), 64'(seen), 64'd1);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(tv[i].lat));
            chk($sformatf("v%0d_count_seq", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_done_ctl", i), 64'({bus.busy, bus.count}), 64'd0);
            chk($sformatf("v%0d_q", i), 64'(bus.q), 64'(tv[i].q));
            chk($sformatf("v%0d_r", i), 64'(bus.r), 64'(tv[i].r));
            chk($sformatf("v%0d_flags", i), 64'({bus.dz, bus.inv}), 64'({tv[i].dz, tv[i].inv}));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
        end
        launch(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        launch(1'b0, 32'd1000, 32'd3);
        wait_done(27, bc, ok, seen);
        chk("ignore_start_done", 64'(seen), 64'd1);
        chk("ignore_start_timing", 64'({ok, 8'(bc)}), 64'({1'b1, 8'd27}));
        chk("ignore_start_q", 64'({bus.q, bus.r}), 64'({32'd14, 32'd2}));
        launch(1'b0, 32'd51, 32'd5);
        chk("b2b_start", 64'({bus.busy, bus.count, bus.done}), 64'({1'b1, 6'd32, 1'b0}));
        wait_done(32, bc, ok, seen);
        chk("b2b_timing", 64'({seen, ok, 8'(bc)}), 64'({1'b1, 1'b1, 8'd32}));
        chk("b2b_result", 64'({bus.q, bus.r}), 64'({32'd10, 32'd1}));
        @(negedge clk);
        launch(1'b0, 32'd999, 32'd4);
        for (int k = 0; k < 40 && bus.count != CW'(10); k++) @(negedge clk);
        chk("cancel_reach_10", 64'(bus.count), 64'd10);
        bus.cancel = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        chk("cancel_ctl", 64'({bus.busy, bus.count, bus.done}), 64'd0);
        chk("cancel_hold", 64'({bus.q, bus.r}), 64'({32'd10, 32'd1}));
        chk_no_done("cancel_no_done", 40);
        launch(1'b0, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1 chk_zero("async_clr");
        #1 clr = 1'b0;
        @(negedge clk);
        chk_no_done("clr_no_done", 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_divsqrt_iter.md
# fpu_divsqrt_iter

Iterative radix-2 divide / square-root responder for the FPU side of the pipelined CPU. It accepts a one-cycle start request from the execute stage and iterates one bit per cycle. It exposes `busy` and a down-counter that the pipeline uses to generate its floating-point stall, then returns the result with a one-cycle `done` pulse. It operates on unsigned integer operands, i.e. mantissas prepared by the FPU front end.

## Interface
- `WIDTH`, 32: operand width; must be even and ≥4.
- `COUNT_W`, derived ($clog2(WIDTH)+1): width of `count`; not overridable.

- `clk`  in  1  clock; all state changes on the rising edge.
- `clr`  in  1  reset; asynchronous, active-high; clears all state immediately.
- `start`  in  1  request strobe, sampled on `clk`.
- `op`  in  1  0 = divide, 1 = square root.
- `a`  in  WIDTH  dividend / radicand.
- `b`  in  WIDTH  divisor; ignored for sqrt.
- `cancel`  in  1  synchronous abort, used on pipeline flush.
- `busy`  out  1  iteration in progress; drives the FPU stall.
- `count`  out  COUNT_W  iterations remaining.
- `done`  out  1  one-cycle completion pulse.
- `q`  out  WIDTH  quotient / root.
- `r`  out  WIDTH  remainder, zero-extended.
- `dz`  out  1  divide-by-zero flag, valid with `done`.
- `inv`  out  1  unsupported op flag, valid with `done`.

## Operation
- Two states: IDLE and RUN. `done` is a registered pulse and is not a separate state.
- IDLE + `start` with `op=0`:
  - Latch `a` and `b`.
  - `count` ← WIDTH, `busy` ← 1, go to RUN.
- IDLE + `start` with `op=1`:
  - Latch `a`.
  - `count` ← WIDTH/2, `busy` ← 1, go to RUN.
- RUN, each edge: perform one restoring iteration and decrement `count`.
- Transition to IDLE on the edge where `count` goes 1→0. On that edge:
  - Register `q` and `r`.
  - `done` ← 1 for exactly one cycle.
  - `busy` ← 0.
- Divide results: `q = a / b`, `r = a % b`.
- Sqrt results:
  - `q = floor(sqrt(a))`, held in the low WIDTH/2 bits; upper bits are 0.
  - `r = a − q²`, which is at most WIDTH/2+1 bits.
- Divide by zero (`b=0`) takes the normal latency. At completion: `q` = all ones, `r = a`, `dz=1`.
- `start` while `busy=1` is ignored, with no effect on the operation in flight.
- `start` in the cycle where `done=1` is accepted, because the block is already IDLE. Back-to-back operations have zero bubble.
- `cancel=1` takes priority over `start`:
  - RUN → IDLE, `busy` ← 0, `count` ← 0.
  - No `done` pulse is produced.
  - `q`, `r`, `dz` and `inv` keep their previous values.
- `q`, `r`, `dz` and `inv` hold their values until the next completion.

## Timing
- Values on `clr`: all outputs are 0, and the state is IDLE. If `clr` is asserted during RUN, the operation is lost and no `done` is produced.
- Start sampled at edge 0:
  - `busy` is high from edge 0.
  - `done` is high after edge N, where N = WIDTH for divide and WIDTH/2 for sqrt.
- `count` reads N, N−1, …, 1 during RUN and 0 in the `done` cycle.
- `busy` and `done` are never high in the same cycle.
- The stall window seen by the pipeline is exactly N cycles.

## Configuration
- `FPU_DIVSQRT_SQRT_EN` defined: square-root datapath is present, as described above.
- `FPU_DIVSQRT_SQRT_EN` undefined:
  - No sqrt hardware.
  - A request with `op=1` never enters RUN. On the next edge: `done=1`, `inv=1`, `q=0`, `r=0`, `busy` stays 0.
- `inv` is always 0 when the macro is defined.

## Structure
- Shared package `fpu_pkg`:
  - Op encodings `OP_DIV=1'b0`, `OP_SQRT=1'b1`.
  - State enum `{S_IDLE, S_RUN}`.
- Sub-module `divsqrt_step`: combinational single-iteration step (partial remainder, trial subtract, next quotient bit), parameterised by WIDTH. Both ops share it:
  - Divide: trial value is `b`.
  - Sqrt: trial value is `{q, 2'b01}`.
- The top level holds the FSM, counter, operand shift registers and the result registers.

## Test plan
- Divide, WIDTH=32: `a=100`, `b=7` → `busy` high for 32 cycles, `count` 32→1, then `done` with `q=14`, `r=2`, `dz=0`.
- Sqrt: `a=1000000` → 16 busy cycles, then `q=1000`, `r=0`; `a=10` → `q=3`, `r=1`.
- Divide by zero: `a=5`, `b=0` → `done` after 32 cycles with `q=32'hFFFFFFFF`, `r=5`, `dz=1`.
- Busy handling:
  - `start` at cycle 5 of a running divide → ignored; original result is returned on time.
  - `start` in the `done` cycle → new op begins with zero bubble.
- `cancel` at `count=10` → `busy=0` and `count=0` next cycle; no `done`; old `q`/`r` retained.
- Async `clr` pulse mid-RUN, between clock edges → all outputs 0 immediately. Without `FPU_DIVSQRT_SQRT_EN`, `op=1` → `done` and `inv=1` one cycle later.
